// File: rtl/fpu_pkg.sv
// Shared definitions for the FP dispatcher: state encoding, opcode names,
// the default unit count and the request record latched on handshake.
package fpu_pkg;

   localparam int unsigned FPU_NUNIT_DEF = 8;

   typedef logic [1:0] fpu_state_t;
   localparam fpu_state_t ST_IDLE  = 2'd0;
   localparam fpu_state_t ST_ISSUE = 2'd1;
   localparam fpu_state_t ST_WAIT  = 2'd2;
   localparam fpu_state_t ST_DONE  = 2'd3;

   localparam logic [3:0] FOP_NEG = 4'd0;
   localparam logic [3:0] FOP_ADD = 4'd1;
   localparam logic [3:0] FOP_SUB = 4'd2;
   localparam logic [3:0] FOP_MUL = 4'd3;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
   } fpu_req_t;

   function automatic logic fpu_op_legal(input logic [3:0] op, input int unsigned nunit);
      return 32'(op) < nunit;
   endfunction

endpackage

// File: rtl/fpu_dispatch_timer.sv
// WAIT-state watchdog: clears on clear_i, counts enabled cycles, and flags
// expiry on the cycle whose increment would reach LIMIT.
module fpu_dispatch_timer #(
   parameter int unsigned LIMIT = 64
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = enable_i && (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && !expire_o)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fpu_dispatch.sv
// Single-outstanding FP dispatcher: issue pulse to one unit, wait for its c_valid,
// one-cycle writeback. Define FPU_DISPATCH_TIMEOUT_EN to add the WAIT watchdog.
module fpu_dispatch
   import fpu_pkg::*;
#(
   parameter int unsigned NUNIT          = FPU_NUNIT_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [3:0]          req_op,
   input  logic [31:0]         req_a,
   input  logic [31:0]         req_b,
   input  logic [4:0]          req_rd,
   output logic [31:0]         fu_a_data,
   output logic [31:0]         fu_b_data,
   output logic [NUNIT-1:0]    fu_a_valid,
   input  logic [NUNIT*32-1:0] fu_c_data,
   input  logic [NUNIT-1:0]    fu_c_valid,
   output logic                wb_valid,
   output logic [4:0]          wb_rd,
   output logic [31:0]         wb_data,
   output logic                wb_err
);

   if (NUNIT < 1 || NUNIT > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("fpu_dispatch: NUNIT must be 1..16 and TIMEOUT_CYCLES >= 1");
   end

   fpu_state_t       state_q, state_d;
   fpu_req_t         req_q, req_d;
   logic [NUNIT-1:0] sel_q, sel_d;
   logic [NUNIT-1:0] fu_a_valid_q, fu_a_valid_d;
   logic             req_ready_q, req_ready_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             wb_err_q, wb_err_d;

   logic [NUNIT-1:0] req_sel;
   logic [31:0]      c_data_sel;
   logic             c_hit;
   logic             timeout;

   assign req_sel = NUNIT'(1) << req_op;
   assign c_hit   = (state_q == ST_WAIT) && |(fu_c_valid & sel_q);

   always_comb begin
      c_data_sel = '0;
      for (int i = 0; i < NUNIT; i++)
         if (sel_q[i]) c_data_sel = c_data_sel | fu_c_data[32*i +: 32];
   end

`ifdef FPU_DISPATCH_TIMEOUT_EN
   fpu_dispatch_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .clear_i  (state_q == ST_ISSUE),
      .enable_i (state_q == ST_WAIT),
      .expire_o (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      sel_d        = sel_q;
      fu_a_valid_d = '0;
      wb_valid_d   = 1'b0;
      wb_rd_d      = '0;
      wb_data_d    = '0;
      wb_err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_d = '{a: req_a, b: req_b, rd: req_rd};
               sel_d = req_sel;
               if (fpu_op_legal(req_op, NUNIT)) begin
                  state_d      = ST_ISSUE;
                  fu_a_valid_d = req_sel;
               end else begin
                  state_d    = ST_DONE;
                  wb_valid_d = 1'b1;
                  wb_rd_d    = req_rd;
                  wb_err_d   = 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            // A result arriving on the expiry cycle takes priority over the timeout.
            if (c_hit || timeout) begin
               state_d    = ST_DONE;
               wb_valid_d = 1'b1;
               wb_rd_d    = req_q.rd;
               wb_data_d  = c_hit ? c_data_sel : 32'h0;
               wb_err_d   = !c_hit;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values.
   // NOTE: operand and result registers are reset too, because they drive ports that must read 0 after reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         sel_q        <= '0;
         fu_a_valid_q <= '0;
         req_ready_q  <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         wb_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         sel_q        <= sel_d;
         fu_a_valid_q <= fu_a_valid_d;
         req_ready_q  <= req_ready_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         wb_err_q     <= wb_err_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign fu_a_data  = req_q.a;
   assign fu_b_data  = req_q.b;
   assign fu_a_valid = fu_a_valid_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Scoreboard bench for fpu_dispatch: stimulus pushes expected issue/writeback
// events with their cycle numbers; a monitor pops and compares them.
module tb_fpu_dispatch;

   localparam int NUNIT = 8;
   localparam int TMO   = 16;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic [3:0]          req_op = '0;
   logic [31:0]         req_a = '0, req_b = '0;
   logic [4:0]          req_rd = '0;
   logic [31:0]         fu_a_data, fu_b_data;
   logic [NUNIT-1:0]    fu_a_valid;
   logic [NUNIT*32-1:0] fu_c_data = '0;
   logic [NUNIT-1:0]    fu_c_valid = '0;
   logic                wb_valid;
   logic [4:0]          wb_rd;
   logic [31:0]         wb_data;
   logic                wb_err;

   fpu_dispatch #(.NUNIT(NUNIT), .TIMEOUT_CYCLES(TMO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .fu_a_data(fu_a_data), .fu_b_data(fu_b_data), .fu_a_valid(fu_a_valid),
      .fu_c_data(fu_c_data), .fu_c_valid(fu_c_valid),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc++;

   int n_vec = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; logic err; } wb_exp_t;
   typedef struct { int cyc; logic [NUNIT-1:0] onehot; logic [31:0] a; logic [31:0] b; } iss_exp_t;
   wb_exp_t  wb_q[$];
   iss_exp_t iss_q[$];

   int unit_lat[NUNIT];   // 0 means the unit never answers
   bit stray_en = 1'b0;

   // Functional-unit behaviours; unit 1 is a toy adder that knows 1.0+2.0.
   function automatic logic [31:0] fu_func(input int u, input logic [31:0] a, input logic [31:0] b);
      case (u)
         0: return a ^ 32'h8000_0000;
         1: return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
         2: return a - b;
         3: return a * b;
         default: return a ^ {b[15:0], b[31:16]} ^ 32'(u);
      endcase
   endfunction

   // Monitor: compares every issue pulse and writeback against the queues.
   always @(negedge aclk) begin
      if (wb_valid) begin
         if (wb_q.size() == 0) check("wb_unexpected", 32'(wb_valid), 32'd0);
         else begin
            wb_exp_t e;
            e = wb_q.pop_front();
            check("wb_cycle", cyc, e.cyc);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_data", wb_data, e.data);
            check("wb_err", 32'(wb_err), 32'(e.err));
         end
      end
      if (fu_a_valid != '0) begin
         if (iss_q.size() == 0) check("issue_unexpected", 32'(fu_a_valid), 32'd0);
         else begin
            iss_exp_t e;
            e = iss_q.pop_front();
            check("issue_cycle", cyc, e.cyc);
            check("issue_onehot", 32'(fu_a_valid), 32'(e.onehot));
            check("issue_a", fu_a_data, e.a);
            check("issue_b", fu_b_data, e.b);
         end
      end
   end

   // Unit bank: answers the issued unit after its latency, holds c_valid 1..3
   // cycles, and optionally sprays c_valid on units it is not answering for.
   initial begin : responder
      bit               pend = 1'b0;
      int               p_unit = 0, p_cnt = 0, p_hold = 0;
      logic [31:0]      p_res = '0;
      logic [NUNIT-1:0] v, mask;
      forever begin
         @(posedge aclk);
         #1;
         for (int i = 0; i < NUNIT; i++)
            fu_c_data[32*i +: 32] = (i == 2) ? 32'hDEAD_BEEF : $urandom;
         mask = '0;
         if (pend) mask[p_unit] = 1'b1;
         v = stray_en ? (NUNIT'($urandom) & ~mask) : '0;
         if (pend) begin
            if (p_cnt > 0) p_cnt--;
            if (p_cnt == 0) begin
               v[p_unit] = 1'b1;
               fu_c_data[32*p_unit +: 32] = p_res;
               p_hold--;
               if (p_hold == 0) pend = 1'b0;
            end
         end
         fu_c_valid = v;
         @(negedge aclk);
         for (int i = 0; i < NUNIT; i++) begin
            if (fu_a_valid[i] && unit_lat[i] > 0) begin
               pend   = 1'b1;
               p_unit = i;
               p_cnt  = unit_lat[i];
               p_hold = $urandom_range(1, 3);
               p_res  = fu_func(i, fu_a_data, fu_b_data);
            end
         end
      end
   end

   task automatic do_req(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expect_wb);
      int k, l, wbc, waited;
      iss_exp_t ie;
      waited = 0;
      do begin
         @(negedge aclk);
         waited++;
      end while (!req_ready && waited < 300);
      if (!req_ready) begin
         check("ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid = 1'b1; req_op = 4'(op); req_a = a; req_b = b; req_rd = rd;
      k = cyc;
      if (op < NUNIT) begin
         l = unit_lat[op];
         ie.cyc = k + 1; ie.onehot = '0; ie.onehot[op] = 1'b1; ie.a = a; ie.b = b;
         iss_q.push_back(ie);
         wbc = (l > 0) ? k + 2 + l : k + 2 + TMO;
         if (expect_wb)
            wb_q.push_back('{cyc: wbc, rd: rd, data: (l > 0) ? fu_func(op, a, b) : 32'h0, err: (l == 0)});
      end else begin
         wbc = k + 1;
         if (expect_wb) wb_q.push_back('{cyc: wbc, rd: rd, data: 32'h0, err: 1'b1});
      end
      @(posedge aclk);
      #1;
      req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
      if (!expect_wb) return;
      waited = 0;
      do begin
         @(negedge aclk);
         waited++;
      end while (!req_ready && waited < 300);
      check("ready_cycle", cyc, wbc + 1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int op;
      unit_lat[0] = 1;
      unit_lat[1] = 4;
      for (int i = 2; i < NUNIT; i++) unit_lat[i] = $urandom_range(1, 6);

      // Reset state
      repeat (3) @(negedge aclk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_a_valid", 32'(fu_a_valid), 32'd0);
      check("rst_a_data", fu_a_data, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("rst_ready_after", 32'(req_ready), 32'd1);

      // Directed: negate, add, illegal op, strays while waiting on unit 1
      do_req(0, 32'h3F80_0000, $urandom, 5'd5, 1'b1);
      do_req(1, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1'b1);
      do_req(9, $urandom, $urandom, 5'd3, 1'b1);
      stray_en = 1'b1;
      do_req(1, 32'h3F80_0000, 32'h4000_0000, 5'd11, 1'b1);
      stray_en = 1'b0;

      // Reset in the middle of WAIT; the late unit-1 answer must be ignored
      do_req(1, $urandom, $urandom, 5'd9, 1'b0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b0;
      @(negedge aclk);
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_wb_valid", 32'(wb_valid), 32'd0);
      check("midrst_a_data", fu_a_data, 32'd0);
      check("midrst_b_data", fu_b_data, 32'd0);
      check("midrst_wb_rd", 32'(wb_rd), 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("midrst_ready_after", 32'(req_ready), 32'd1);
      repeat (10) @(negedge aclk);
      do_req(1, 32'h1234_5678, 32'h0000_1111, 5'd20, 1'b1);

      // Randomized traffic, some illegal opcodes, strays on and off
      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 4) == 0) ? $urandom_range(NUNIT, 15) : $urandom_range(0, NUNIT - 1);
         stray_en = $urandom_range(0, 1) == 1;
         do_req(op, $urandom, $urandom, 5'($urandom), 1'b1);
      end
      stray_en = 1'b0;

`ifdef FPU_DISPATCH_TIMEOUT_EN
      unit_lat[5] = 0;
      do_req(5, $urandom, $urandom, 5'd17, 1'b1);
      unit_lat[5] = 3;
      do_req(5, $urandom, $urandom, 5'd18, 1'b1);
`endif

      repeat (20) @(negedge aclk);
      check("wb_pending", 32'(wb_q.size()), 32'd0);
      check("issue_pending", 32'(iss_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
